// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite slave register file with byte strobes and SLVERR on unmapped words
module axi_lite_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_NUM_REGS = 4
) (
  input  logic                                     ACLK,
  input  logic                                     ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            AWADDR,
  input  logic [2:0]                               AWPROT,
  input  logic                                     AWVALID,
  output logic                                     AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]            WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          WSTRB,
  input  logic                                     WVALID,
  output logic                                     WREADY,
  output logic [1:0]                               BRESP,
  output logic                                     BVALID,
  input  logic                                     BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]            ARADDR,
  input  logic [2:0]                               ARPROT,
  input  logic                                     ARVALID,
  output logic                                     ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]            RDATA,
  output logic [1:0]                               RRESP,
  output logic                                     RVALID,
  input  logic                                     RREADY,
  output logic [C_S_AXI_DATA_WIDTH*C_NUM_REGS-1:0] reg_out
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int NB = DW / 8;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic en, aw_done, w_done, commit, b_hs, r_hs, ar_hs, aw_ok, ar_ok;
  logic [AW-3:0] aw_idx;
  logic [DW-1:0] w_data, rd_word;
  logic [NB-1:0] w_strb;
  logic [DW-1:0] regs [C_NUM_REGS];
  logic unused;
  assign unused = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
  assign commit = w_state == W_IDLE && aw_done && w_done;
  assign b_hs = BVALID && BREADY;
  assign r_hs = RVALID && RREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign aw_ok = int'(aw_idx) < C_NUM_REGS;
  assign ar_ok = int'(ARADDR[AW-1:2]) < C_NUM_REGS;
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
      en <= 1'b0;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
      en <= 1'b1;
    end
  end
  always_comb begin
    w_next = w_state == W_IDLE ? (commit ? W_RESP : W_IDLE) : (b_hs ? W_IDLE : W_RESP);
    r_next = r_state == R_IDLE ? (ar_hs ? R_DATA : R_IDLE) : (r_hs ? R_IDLE : R_DATA);
  end
  always_comb begin
    AWREADY = en && w_state == W_IDLE && !aw_done;
    WREADY = en && w_state == W_IDLE && !w_done;
    BVALID = w_state == W_RESP;
  end
  always_comb begin
    ARREADY = en && r_state == R_IDLE;
    RVALID = r_state == R_DATA;
  end
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < C_NUM_REGS; i++) if (int'(ARADDR[AW-1:2]) == i) rd_word = regs[i];
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_done <= 1'b0;
      w_done <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      BRESP <= 2'b00;
      RDATA <= '0;
      RRESP <= 2'b00;
      for (int i = 0; i < C_NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (AWVALID && AWREADY) begin
        aw_done <= 1'b1;
        aw_idx <= AWADDR[AW-1:2];
      end
      if (WVALID && WREADY) begin
        w_done <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (commit) begin
        BRESP <= aw_ok ? 2'b00 : 2'b10;
        for (int i = 0; i < C_NUM_REGS; i++)
          for (int k = 0; k < NB; k++)
            if (int'(aw_idx) == i && w_strb[k]) regs[i][8*k+:8] <= w_data[8*k+:8];
      end
      if (b_hs) begin
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (ar_hs) begin
        RDATA <= rd_word;
        RRESP <= ar_ok ? 2'b00 : 2'b10;
      end
    end
  end
  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_out
    assign reg_out[DW*i+:DW] = regs[i];
  end
endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI4-Lite slave register file that answers the master BFM in the block-design testbenches and gives each IP its software-visible control/status window. It accepts single-beat writes and reads from an AXI4-Lite master, stores C_NUM_REGS 32-bit words with byte-strobe support, and returns OKAY for mapped addresses and SLVERR otherwise. It sits between the interconnect/BFM master port and the IP core's register fabric.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 6: byte address width; word index = addr[C_S_AXI_ADDR_WIDTH-1:2].
- C_NUM_REGS, 4: number of mapped registers (≤ 2^(C_S_AXI_ADDR_WIDTH-2)).
- ACLK in 1: clock; all logic on rising edge.
- ARESET in 1: reset, synchronous and active-high.
- AWADDR in C_S_AXI_ADDR_WIDTH, AWPROT in 3 (ignored), AWVALID in 1, AWREADY out 1: write address channel.
- WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1: write data channel.
- BRESP out 2, BVALID out 1, BREADY in 1: write response channel.
- ARADDR in C_S_AXI_ADDR_WIDTH, ARPROT in 3 (ignored), ARVALID in 1, ARREADY out 1: read address channel.
- RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1: read data channel.
- reg_out out 32*C_NUM_REGS: flat register contents to core; reg i at bits [32i+31:32i].

## Operation
- Write path FSM: W_IDLE, W_RESP.
  - W_IDLE: AWREADY=1 until AW captured, WREADY=1 until W captured; AW and W accepted in either order or same cycle; each latched independently and its READY dropped once captured.
  - When both latched: commit write (bytes with WSTRB[k]=1 updated, others kept), BVALID=1, go W_RESP.
  - W_RESP: hold BVALID/BRESP until BVALID&&BREADY; then clear latches, return W_IDLE with AWREADY=WREADY=1.
- Read path FSM: R_IDLE, R_DATA.
  - R_IDLE: ARREADY=1; on ARVALID capture address, load RDATA/RRESP, RVALID=1, ARREADY=0, go R_DATA.
  - R_DATA: hold RDATA/RRESP/RVALID until RVALID&&RREADY; then ARREADY=1, R_IDLE.
- Decode: index < C_NUM_REGS → OKAY (2'b00); else SLVERR (2'b10), write discarded, RDATA=0. addr[1:0] ignored.
- Write and read paths independent; both may be active concurrently.
- Same-register write commit and read capture on same edge: read returns pre-write value.

## Timing
- Reset values (during and first edge after ARESET): AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0, all registers 0. First edge with ARESET=0 sets AWREADY=WREADY=ARREADY=1.
- AW and W handshaking at edge N → register updated and BVALID=1 after edge N+1. AW at N, W at N+k → BVALID after N+k+1.
- Minimum write occupancy: 3 cycles (accept, commit, response handshake) with BREADY held high.
- AR handshake at edge M → RVALID=1, RDATA valid after edge M; with RREADY high, next AR accepted at edge M+2.
- Back-pressure: BVALID/RVALID and payloads stable while READY low; no new AW/W/AR accepted while response pending.
- reg_out reflects committed values combinationally from the register array (one-cycle after commit edge).
- ARESET asserted mid-transaction: abandon all latched/pending transactions; no response issued; outputs to reset values next edge.

## Test plan
- Post-reset: ARESET high 25 cycles then low → READYs 0 during reset, all 1 one cycle after release; read of 0x0..0xC returns 0x00000000, OKAY.
- Sequential write/read at 0x0,0x4,0x8,0xC with 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 → each BRESP=OKAY, each readback equal, reg_out matches.
- Byte strobes: write 0xFFFFFFFF to 0x4, then 0x12345678 with WSTRB=4'b0101 → read 0xFF34FF78.
- Channel ordering: W presented 5 cycles before AW, then AW-only-first case → single BVALID each, after AW+1 cycle; data committed correctly; back-to-back W not accepted until B handshake.
- Back-pressure: BREADY/RREADY held low 10 cycles → BVALID/RVALID and BRESP/RDATA stable; concurrent read of reg being written in commit cycle returns old value.
- Decode error and reset mid-op: write 0xCAFEF00D to 0x10 (C_NUM_REGS=4) → BRESP=2'b10, registers unchanged; read 0x10 → RDATA=0, RRESP=2'b10; assert ARESET while BVALID pending → BVALID=0 next edge, registers cleared.
